// File: rtl/ram_scan_reader.sv
// Burst reader for the pattern RAM: sequential reads, latency absorption,
// and a credit-limited skid FIFO feeding an address-tagged valid/ready stream.
module ram_scan_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_count,
    output logic                  o_re,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int FIFO_DEPTH = RD_LATENCY + 3;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = 4;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   left_q, left_d;
    logic                  re_q, re_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [RD_LATENCY-1:0] pv_q, pv_d;
    logic [ADDR_WIDTH-1:0] pa_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] pa_d [RD_LATENCY];
    logic [DATA_WIDTH-1:0] md_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] md_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] ma_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] ma_d [FIFO_DEPTH];
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [CW-1:0]         inflight;
    logic                  push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // Reads issued but not yet captured: the o_re slot plus the tag pipe.
    always_comb begin
        inflight = CW'(re_q);
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pv_q[i]);
        end
    end

    assign push = pv_q[RD_LATENCY-1];
    assign pop  = (occ_q != '0) && i_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        re_d    = 1'b0;
        raddr_d = raddr_q;
        pv_d    = pv_q;
        pa_d    = pa_q;
        md_d    = md_q;
        ma_d    = ma_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        pv_d[0] = re_q;
        pa_d[0] = raddr_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
        end
        if (push) begin
            md_d[wp_q] = i_rdata;
            ma_d[wp_q] = pa_q[RD_LATENCY-1];
            wp_d = nxt(wp_q);
        end
        if (pop) begin
            rp_d = nxt(rp_q);
        end
        occ_d = occ_q + CW'(push) - CW'(pop);
        unique case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    addr_d  = i_start_addr;
                    left_d  = {1'b0, i_count} + ONE_W;
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((inflight + occ_q) < DEPTH_C) begin
                    re_d    = 1'b1;
                    raddr_d = addr_q;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    left_d  = left_q - ONE_W;
                    if (left_q == ONE_W) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!re_q && (pv_q == '0) && (occ_d == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort drops every tag, so stale RAM data is never captured.
        if (i_abort) begin
            state_d = IDLE;
            re_d    = 1'b0;
            pv_d    = '0;
            wp_d    = '0;
            rp_d    = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            re_q    <= 1'b0;
            raddr_q <= '0;
            pv_q    <= '0;
            pa_q    <= '{default: '0};
            md_q    <= '{default: '0};
            ma_q    <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            re_q    <= re_d;
            raddr_q <= raddr_d;
            pv_q    <= pv_d;
            pa_q    <= pa_d;
            md_q    <= md_d;
            ma_q    <= ma_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            occ_q   <= occ_d;
        end
    end

    assign o_re    = re_q;
    assign o_raddr = raddr_q;
    assign o_valid = (occ_q != '0);
    assign o_data  = md_q[rp_q];
    assign o_addr  = ma_q[rp_q];
    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == DONE);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_arstn)
        !(push && !pop && !i_abort && (occ_q == DEPTH_C)));

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader: one instance per read latency,
// each backed by a behavioural RAM returning addr[7:0].
module tb_ram_scan_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st1 = 1'b0, st2 = 1'b0, abort = 1'b0, ready = 1'b1;
    logic [15:0] sa = '0, cnt = '0;
    logic        re1, v1, busy1, done1, re2, v2, busy2, done2;
    logic [15:0] raddr1, a1, raddr2, a2;
    logic [7:0]  d1, d2, rd1, rd2, r2a;

    logic        use2 = 1'b0;
    logic        m_re, m_valid, m_busy, m_done;
    logic [15:0] m_raddr, m_addr;
    logic [7:0]  m_data;

    int          nvec = 0, nerr = 0;
    int          nx, nre, first_re_k, first_v_k, done_k, ndone;
    int          stall_bad, maxout, nre_stall;
    logic [15:0] first_raddr;
    logic        busy_after;
    logic [15:0] ta [64];
    logic [7:0]  td [64];
    int          tk [64];

    always #5 clk = ~clk;

    always @(posedge clk) if (re1) rd1 <= raddr1[7:0];
    always @(posedge clk) begin
        if (re2) r2a <= raddr2[7:0];
        rd2 <= r2a;
    end

    ram_scan_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RD_LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_arstn(rst_n), .i_start(st1), .i_abort(abort),
        .i_start_addr(sa), .i_count(cnt), .o_re(re1), .o_raddr(raddr1),
        .i_rdata(rd1), .o_valid(v1), .o_data(d1), .o_addr(a1),
        .i_ready(ready), .o_busy(busy1), .o_done(done1));

    ram_scan_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RD_LATENCY(2)) u_dut2 (
        .i_clk(clk), .i_arstn(rst_n), .i_start(st2), .i_abort(abort),
        .i_start_addr(sa), .i_count(cnt), .o_re(re2), .o_raddr(raddr2),
        .i_rdata(rd2), .o_valid(v2), .o_data(d2), .o_addr(a2),
        .i_ready(ready), .o_busy(busy2), .o_done(done2));

    assign m_re    = use2 ? re2 : re1;
    assign m_raddr = use2 ? raddr2 : raddr1;
    assign m_valid = use2 ? v2 : v1;
    assign m_data  = use2 ? d2 : d1;
    assign m_addr  = use2 ? a2 : a1;
    assign m_busy  = use2 ? busy2 : busy1;
    assign m_done  = use2 ? done2 : done1;

    // Called just after a negedge; start is sampled at the next edge (S).
    task automatic kick(input logic [15:0] a, input logic [15:0] c);
        sa = a;
        cnt = c;
        if (use2) st2 = 1'b1;
        else st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        st2 = 1'b0;
    endtask

    // Observes cycles S+1.. (k) until one cycle after o_done or budget.
    task automatic collect(input int budget, input int mode, input int inj_k);
        logic pv;
        logic [15:0] pa;
        logic [7:0] pd;
        nx = 0; nre = 0; first_re_k = -1; first_v_k = -1; done_k = -1;
        ndone = 0; stall_bad = 0; maxout = 0; nre_stall = -1;
        pv = 1'b0; pa = '0; pd = '0; busy_after = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (use2) st2 = (k == inj_k);
            else st1 = (k == inj_k);
            if (k == inj_k) sa = 16'h0500;
            if (m_valid && first_v_k < 0) first_v_k = k;
            case (mode)
                1: ready = ($urandom_range(9) < 3);
                2: ready = (k >= first_v_k + 20);
                default: ready = 1'b1;
            endcase
            if (mode == 2 && first_v_k >= 0 && k == first_v_k + 19) nre_stall = nre;
            if (pv && (!m_valid || m_data !== pd || m_addr !== pa)) stall_bad++;
            if (m_re) begin
                nre++;
                if (first_re_k < 0) begin
                    first_re_k = k;
                    first_raddr = m_raddr;
                end
            end
            if (m_valid && ready) begin
                if (nx < 64) begin
                    ta[nx] = m_addr;
                    td[nx] = m_data;
                    tk[nx] = k;
                end
                nx++;
            end
            pv = m_valid && !ready;
            pd = m_data;
            pa = m_addr;
            if (nre - nx > maxout) maxout = nre - nx;
            if (m_done) begin
                ndone++;
                done_k = k;
            end
            if (done_k >= 0 && k == done_k + 1) begin
                busy_after = m_busy;
                break;
            end
        end
        st1 = 1'b0;
        st2 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        nvec++;
        if ({re1, v1, busy1, done1, re2, v2, busy2, done2} !== 8'h00) begin
            nerr++;
            $display("FAIL rst_ctl got %b want 00000000",
                     {re1, v1, busy1, done1, re2, v2, busy2, done2});
        end
        nvec++;
        if ({raddr1, d1, a1, raddr2, d2, a2} !== '0) begin
            nerr++;
            $display("FAIL rst_data got %h/%h/%h want 0", raddr1, d1, a1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if ({busy1, v1, busy2, v2} !== 4'b0000) begin
            nerr++;
            $display("FAIL rst_release got %b want 0000", {busy1, v1, busy2, v2});
        end
    endtask

    task automatic test_basic;
        use2 = 1'b0;
        kick(16'h0010, 16'd7);
        collect(40, 0, -1);
        nvec++;
        if (first_re_k != 1 || first_raddr !== 16'h0010) begin
            nerr++;
            $display("FAIL s1_first_re got k=%0d a=%h want k=1 a=0010", first_re_k, first_raddr);
        end
        nvec++;
        if (first_v_k != 3) begin
            nerr++;
            $display("FAIL s1_first_valid got %0d want 3", first_v_k);
        end
        nvec++;
        if (nx != 8) begin
            nerr++;
            $display("FAIL s1_count got %0d want 8", nx);
        end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (ta[i] !== 16'(16'h0010 + i) || td[i] !== 8'(16 + i) || tk[i] != 3 + i) begin
                nerr++;
                $display("FAIL s1_word%0d got a=%h d=%h k=%0d want a=%h d=%h k=%0d",
                         i, ta[i], td[i], tk[i], 16'(16 + i), 8'(16 + i), 3 + i);
            end
        end
        nvec++;
        if (done_k != 11 || ndone != 1 || busy_after !== 1'b0) begin
            nerr++;
            $display("FAIL s1_done got k=%0d n=%0d busy=%b want k=11 n=1 busy=0",
                     done_k, ndone, busy_after);
        end
    endtask

    task automatic test_wrap;
        use2 = 1'b1;
        kick(16'hFFFE, 16'd3);
        collect(40, 0, -1);
        nvec++;
        if (first_v_k != 4 || nx != 4) begin
            nerr++;
            $display("FAIL s2_timing got first=%0d n=%0d want first=4 n=4", first_v_k, nx);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (ta[i] !== 16'(16'hFFFE + i) || td[i] !== 8'(8'hFE + i) || tk[i] != 4 + i) begin
                nerr++;
                $display("FAIL s2_word%0d got a=%h d=%h k=%0d want a=%h d=%h k=%0d",
                         i, ta[i], td[i], tk[i], 16'(16'hFFFE + i), 8'(8'hFE + i), 4 + i);
            end
        end
        nvec++;
        if (done_k != 8 || ndone != 1) begin
            nerr++;
            $display("FAIL s2_done got k=%0d n=%0d want k=8 n=1", done_k, ndone);
        end
        use2 = 1'b0;
    endtask

    task automatic test_random_ready;
        use2 = 1'b0;
        kick(16'h0120, 16'd15);
        collect(400, 1, -1);
        nvec++;
        if (nx != 16 || ndone != 1) begin
            nerr++;
            $display("FAIL s3_count got n=%0d done=%0d want n=16 done=1", nx, ndone);
        end
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (ta[i] !== 16'(16'h0120 + i) || td[i] !== 8'(8'h20 + i)) begin
                nerr++;
                $display("FAIL s3_word%0d got a=%h d=%h want a=%h d=%h",
                         i, ta[i], td[i], 16'(16'h0120 + i), 8'(8'h20 + i));
            end
        end
        nvec++;
        if (stall_bad != 0 || maxout > 4) begin
            nerr++;
            $display("FAIL s3_stall got unstable=%0d maxout=%0d want 0 and <=4", stall_bad, maxout);
        end
        ready = 1'b1;
    endtask

    task automatic test_stall;
        use2 = 1'b0;
        kick(16'h0180, 16'd31);
        collect(300, 2, -1);
        nvec++;
        if (first_v_k != 3 || nre_stall != 4 || maxout != 4) begin
            nerr++;
            $display("FAIL s4_credit got first=%0d reads=%0d maxout=%0d want 3 4 4",
                     first_v_k, nre_stall, maxout);
        end
        nvec++;
        if (nx != 32 || ndone != 1 || stall_bad != 0) begin
            nerr++;
            $display("FAIL s4_count got n=%0d done=%0d unstable=%0d want 32 1 0",
                     nx, ndone, stall_bad);
        end
        for (int i = 0; i < 32; i += 7) begin
            nvec++;
            if (ta[i] !== 16'(16'h0180 + i) || td[i] !== 8'(8'h80 + i)) begin
                nerr++;
                $display("FAIL s4_word%0d got a=%h d=%h want a=%h", i, ta[i], td[i],
                         16'(16'h0180 + i));
            end
        end
        ready = 1'b1;
    endtask

    task automatic test_abort;
        use2 = 1'b0;
        ready = 1'b1;
        kick(16'h0200, 16'd99);
        repeat (3) @(negedge clk);
        nvec++;
        if (v1 !== 1'b1 || busy1 !== 1'b1) begin
            nerr++;
            $display("FAIL s5_pre got valid=%b busy=%b want 1 1", v1, busy1);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        nvec++;
        if ({busy1, v1, re1, done1} !== 4'b0000) begin
            nerr++;
            $display("FAIL s5_abort got %b want 0000", {busy1, v1, re1, done1});
        end
        kick(16'h0040, 16'd3);
        collect(60, 0, -1);
        nvec++;
        if (nx != 4 || first_v_k != 3 || ndone != 1) begin
            nerr++;
            $display("FAIL s5_restart got n=%0d first=%0d done=%0d want 4 3 1", nx, first_v_k, ndone);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (ta[i] !== 16'(16'h0040 + i) || td[i] !== 8'(8'h40 + i)) begin
                nerr++;
                $display("FAIL s5_word%0d got a=%h d=%h want a=%h", i, ta[i], td[i],
                         16'(16'h0040 + i));
            end
        end
        sa = 16'h0700;
        st1 = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        abort = 1'b0;
        nvec++;
        if (busy1 !== 1'b0) begin
            nerr++;
            $display("FAIL s5_abort_wins got busy=%b want 0", busy1);
        end
        repeat (4) @(negedge clk);
        nvec++;
        if ({v1, re1} !== 2'b00) begin
            nerr++;
            $display("FAIL s5_quiet got %b want 00", {v1, re1});
        end
    endtask

    task automatic test_back_to_back;
        use2 = 1'b0;
        kick(16'h0600, 16'd1);
        collect(40, 0, -1);
        nvec++;
        if (nx != 2 || done_k != 5) begin
            nerr++;
            $display("FAIL b2b_first got n=%0d done=%0d want 2 5", nx, done_k);
        end
        kick(16'h0610, 16'd2);
        collect(40, 0, -1);
        nvec++;
        if (nx != 3 || first_v_k != 3 || ndone != 1 ||
            ta[0] !== 16'h0610 || ta[2] !== 16'h0612 || td[1] !== 8'h11) begin
            nerr++;
            $display("FAIL b2b_second got n=%0d first=%0d a0=%h a2=%h d1=%h want 3 3 0610 0612 11",
                     nx, first_v_k, ta[0], ta[2], td[1]);
        end
    endtask

    task automatic test_reset_mid;
        use2 = 1'b0;
        ready = 1'b0;
        kick(16'h0300, 16'd20);
        repeat (4) @(negedge clk);
        nvec++;
        if (v1 !== 1'b1 || re1 !== 1'b1) begin
            nerr++;
            $display("FAIL s6_pre got valid=%b re=%b want 1 1", v1, re1);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({re1, v1, busy1, done1} !== 4'b0000 || {raddr1, d1, a1} !== '0) begin
            nerr++;
            $display("FAIL s6_async got ctl=%b raddr=%h addr=%h want 0",
                     {re1, v1, busy1, done1}, raddr1, a1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        kick(16'h0010, 16'd7);
        collect(40, 0, 2);
        nvec++;
        if (first_v_k != 3 || nx != 8 || done_k != 11 || ndone != 1 || busy_after !== 1'b0) begin
            nerr++;
            $display("FAIL s6_reburst got first=%0d n=%0d done=%0d/%0d busy=%b want 3 8 11/1 0",
                     first_v_k, nx, done_k, ndone, busy_after);
        end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (ta[i] !== 16'(16'h0010 + i) || td[i] !== 8'(16 + i)) begin
                nerr++;
                $display("FAIL s6_word%0d got a=%h d=%h want a=%h", i, ta[i], td[i],
                         16'(16 + i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random_ready();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
